// File: rtl/sensor_axi_slave.sv
// AXI slave that exposes NUM_CH sensor channels as burst-readable 64-word windows,
// plus an EN / CLEAR / MASK / STATUS register block driving a masked interrupt.
module sensor_axi_slave #(
    parameter int NUM_CH = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [7:0]              AWID,
    input  logic [31:0]             AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [7:0]              BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [7:0]              ARID,
    input  logic [31:0]             ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [7:0]              RID,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic [NUM_CH*32-1:0]    sctrl_out,
    input  logic [NUM_CH-1:0]       sctrl_interrupt,
    output logic [5:0]              sctrl_addr,
    output logic [NUM_CH-1:0]       sctrl_en,
    output logic [NUM_CH-1:0]       sctrl_clear,
    output logic                    irq
);

    typedef enum logic [2:0] {IDLE, R_LOAD, R_DATA, W_DATA, W_RESP} state_t;

    localparam logic [13:0] REG_EN     = 14'h0400;
    localparam logic [13:0] REG_CLEAR  = 14'h0401;
    localparam logic [13:0] REG_MASK   = 14'h0402;
    localparam logic [13:0] REG_STATUS = 14'h0403;

    state_t              state_q, state_d;
    logic [7:0]          rid_q, bid_q;
    logic [3:0]          rlen_q, beat_q;
    logic [15:0]         rd_addr, rd_next, wr_addr;
    logic [31:0]         rdata_q, rd_word;
    logic [1:0]          rresp_q;
    logic                rd_err, wr_err, last_beat;
    logic [NUM_CH-1:0]   en_q, mask_q, pending_q, clr_mask;
    logic                ar_hs, aw_hs, w_hs, r_hs;
    logic                unused_bits;

    assign unused_bits = ^{AWLEN, AWADDR[31:16], ARADDR[31:16], WSTRB[3:1], WDATA[31:NUM_CH]};

    assign ar_hs     = ARVALID & ARREADY;
    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign r_hs      = RVALID & RREADY;
    assign last_beat = (beat_q == rlen_q);

    assign sctrl_addr = rd_addr[7:2];
    assign sctrl_en   = en_q;
    assign RID        = RVALID ? rid_q   : 8'h00;
    assign RDATA      = RVALID ? rdata_q : 32'h0;
    assign RRESP      = RVALID ? rresp_q : 2'b00;
    assign RLAST      = RVALID & last_beat;
    assign BID        = BVALID ? bid_q : 8'h00;
    assign BRESP      = (BVALID && wr_err) ? 2'b10 : 2'b00;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every variable in an always_comb gets a default first, otherwise a
    // path that skips it infers a latch.
    always_comb begin
        state_d = state_q;
        ARREADY = 1'b0;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        RVALID  = 1'b0;
        BVALID  = 1'b0;
        case (state_q)
            IDLE: begin
                // Readiness is gated by reset so every AXI output is 0 while held.
                ARREADY = ARESETn;
                AWREADY = ARESETn & ~ARVALID;
                if (ARVALID)      state_d = R_LOAD;
                else if (AWVALID) state_d = W_DATA;
            end
            R_LOAD: state_d = R_DATA;
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && last_beat) state_d = IDLE;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && WLAST) state_d = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read decode of the word currently addressed by the burst pointer.
    always_comb begin
        rd_word = 32'h0;
        rd_err  = 1'b0;
        if (rd_addr[15:12] == 4'h0) begin
            rd_err = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_addr[11:8] == 4'(c)) begin
                    rd_word = sctrl_out[c*32 +: 32];
                    rd_err  = 1'b0;
                end
            end
        end else begin
            case (rd_addr[15:2])
                REG_EN:     rd_word = 32'(en_q);
                REG_CLEAR:  rd_word = 32'h0;
                REG_MASK:   rd_word = 32'(mask_q);
                REG_STATUS: rd_word = 32'(pending_q);
                default:    rd_err  = 1'b1;
            endcase
        end
    end

    // Data-window bursts wrap within the channel's 64 words; register bursts walk the map.
    assign rd_next = (rd_addr[15:12] == 4'h0) ?
                     {rd_addr[15:8], rd_addr[7:2] + 6'd1, rd_addr[1:0]} :
                     rd_addr + 16'd4;

    always_comb begin
        clr_mask = '0;
        if (w_hs && WSTRB[0] && (wr_addr[15:2] == REG_CLEAR || wr_addr[15:2] == REG_STATUS))
            clr_mask = WDATA[NUM_CH-1:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: no storage here is a memory array, so every flop is reset to give
    // the all-zero state the bus sees during reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rid_q       <= '0;
            rlen_q      <= '0;
            beat_q      <= '0;
            rd_addr     <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            bid_q       <= '0;
            wr_addr     <= '0;
            wr_err      <= 1'b0;
            en_q        <= '0;
            mask_q      <= '0;
            pending_q   <= '0;
            sctrl_clear <= '0;
            irq         <= 1'b0;
        end else begin
            sctrl_clear <= '0;
            irq         <= |(pending_q & mask_q);
            // A new interrupt request wins over a same-cycle clear.
            pending_q   <= (pending_q & ~clr_mask) | sctrl_interrupt;

            if (ar_hs) begin
                rid_q   <= ARID;
                rlen_q  <= ARLEN;
                rd_addr <= ARADDR[15:0];
            end
            if (state_q == R_LOAD || (r_hs && !last_beat)) begin
                rdata_q <= rd_word;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
                rd_addr <= rd_next;
                beat_q  <= (state_q == R_LOAD) ? 4'd0 : beat_q + 4'd1;
            end

            if (aw_hs) begin
                bid_q   <= AWID;
                wr_addr <= AWADDR[15:0];
                wr_err  <= 1'b0;
            end
            if (w_hs) begin
                wr_addr <= wr_addr + 16'd4;
                if (WSTRB[0]) begin
                    if (wr_addr[15:12] == 4'h0) begin
                        wr_err <= 1'b1;
                    end else begin
                        case (wr_addr[15:2])
                            REG_EN:     en_q        <= WDATA[NUM_CH-1:0];
                            REG_CLEAR:  sctrl_clear <= WDATA[NUM_CH-1:0];
                            REG_MASK:   mask_q      <= WDATA[NUM_CH-1:0];
                            REG_STATUS: ;
                            default:    wr_err      <= 1'b1;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/sensor_axi_slave.md
SENSOR_AXI_SLAVE -- requirements
Module: sensor_axi_slave

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, range 1-8: number of sensor channels.
REQ-002 SHALL have port ACLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port ARESETn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the AXI slave ports AW*/W*/B*/AR*/R*, with widths from the AXI_define.svh constants (ID 8, ADDR 32, DATA 32, LEN 4, STRB 4).
REQ-005 SHALL have port sctrl_out  in  NUM_CH*32  per-channel sensor read data, channel c at bits [32c+31:32c], valid in the same cycle as sctrl_addr.
REQ-006 SHALL have port sctrl_interrupt  in  NUM_CH  per-channel level interrupt request.
REQ-007 SHALL have port sctrl_addr  out  6  sensor word index, shared by all channels.
REQ-008 SHALL have port sctrl_en  out  NUM_CH  per-channel enable.
REQ-009 SHALL have port sctrl_clear  out  NUM_CH  per-channel one-cycle clear pulse.
REQ-010 SHALL have port irq  out  1  OR of (pending & mask).

Function
REQ-011 SHALL decode the address map on ADDR[15:0]:
- Data window: ADDR[15:12]=0, channel=ADDR[11:8], word=ADDR[7:2].
- Registers: 0x1000 EN (RW), 0x1004 CLEAR (WO, reads 0), 0x1008 MASK (RW), 0x100C STATUS (pending; reads; W1C).
- Register bits above NUM_CH-1 SHALL read 0.
REQ-012 SHALL implement FSM states IDLE, R_LOAD, R_DATA, W_DATA, W_RESP.
REQ-013 SHALL, in IDLE, drive ARREADY=1 and drive AWREADY=!ARVALID, so reads win when ARVALID and AWVALID are both high.
REQ-014 SHALL, on AR handshake, latch ARID, ARLEN, channel and word pointer, then go to R_LOAD.
REQ-015 SHALL, in R_LOAD, register RDATA from the addressed word and go to R_DATA; the first RVALID is 2 cycles after the AR handshake.
REQ-016 SHALL, in R_DATA, hold RVALID=1, RID and RDATA stable until RREADY; on each non-last handshake, load the next word in the same cycle (back-to-back beats, no bubble).
REQ-017 SHALL increment the word pointer modulo 64 (63 wraps to 0); sctrl_addr always equals the pointer of the word being loaded.
REQ-018 SHALL assert RLAST on beat ARLEN (ARLEN+1 beats total), and return to IDLE after the last handshake.
REQ-019 SHALL, for a data-window channel >= NUM_CH, return RDATA=0 and RRESP=2'b10 on every beat; for register reads, return each beat from the incremented address; for unmapped addresses, return RDATA=0 and RRESP=2'b10; otherwise RRESP=2'b00.
REQ-020 SHALL, on AW handshake, latch AWID and the address, then go to W_DATA with WREADY=1.
REQ-021 SHALL apply each W beat to the current address, advancing it by 4 per beat; a beat with WSTRB[0]=0 SHALL have no effect.
REQ-022 SHALL leave to W_RESP only on the handshake of the beat with WLAST=1.
REQ-023 SHALL make BRESP=2'b10 if any beat hit the data window or an unmapped address, else 2'b00; BID=latched AWID; hold BVALID until BREADY; then go to IDLE.
REQ-024 SHALL drive CLEAR writes as sctrl_clear[c]=1 for exactly the cycle after the beat, for each WDATA bit set, and SHALL clear pending[c] at the same time.
REQ-025 SHALL set pending[c] every cycle sctrl_interrupt[c]=1; a set SHALL override a simultaneous W1C or CLEAR.
REQ-026 SHALL register irq (one cycle after pending/mask change).
REQ-027 SHALL drive ARREADY, AWREADY, WREADY, RVALID, BVALID low outside the states named above; RDATA/RID/RLAST/RRESP SHALL be 0 when RVALID=0.

Reset
REQ-028 SHALL, while ARESETn=0, force state=IDLE and EN, MASK, pending, irq, sctrl_clear, sctrl_addr, all AXI outputs and latches to 0.
REQ-029 SHALL, on reset mid-burst, abandon the transaction with no further beats or response; the first cycle after release is IDLE.

Verification
REQ-030 SHALL check: NUM_CH=4, read ch2 at 0x0000_02F8, ARLEN=3, RREADY=1 -> words 62,63,0,1 of ch2; RLAST on beat 4 only; RRESP=0.
REQ-031 SHALL check: the same burst with RREADY toggling 1,0,0,1... -> RDATA/RID stable while stalled; no beat skipped or repeated.
REQ-032 SHALL check: write EN=0x5 then MASK=0x1, pulse sctrl_interrupt=0x1 -> sctrl_en=0x5, STATUS=0x1, irq=1; write CLEAR=0x1 -> one-cycle sctrl_clear=0x1, STATUS=0, irq=0.
REQ-033 SHALL check: ARVALID and AWVALID rising together -> read completes first, then the write; BRESP=0.
REQ-034 SHALL check: read channel 5 (NUM_CH=4) -> RRESP=2'b10, RDATA=0; a write to the data window -> BRESP=2'b10 with EN unchanged.
REQ-035 SHALL check: reset asserted during beat 2 of a 4-beat read -> all outputs 0 immediately; next AR is accepted normally.
